// File: rtl/ts_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ts_fifo_pkg
// Shared constants and types for the MPEG2-TS packet FIFO.
//   TS_PKT_LEN   : bytes per transport-stream packet
//   TS_SYNC_BYTE : TS sync byte value (first byte of every packet)
//   wr_state_e   : write-side packet framing state
// ---------------------------------------------------------------------------
package ts_fifo_pkg;

    localparam int         TS_PKT_LEN   = 188;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        WR_HUNT = 2'd0,   // waiting for a start-of-packet byte
        WR_FILL = 2'd1,   // storing the bytes of a packet
        WR_DROP = 2'd2    // swallowing the rest of an overflowed packet
    } wr_state_e;

endpackage

// File: rtl/ts_fifo_ram.sv
// ---------------------------------------------------------------------------
// ts_fifo_ram
// Simple dual-port RAM: one write port, one read port with a registered
// output. Maps onto block RAM.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable (output register loads only when set)
//   raddr_i  : read address
//   rdata_o  : read data, valid the cycle after re_i
// ---------------------------------------------------------------------------
module ts_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ts_packet_fifo.sv
// ---------------------------------------------------------------------------
// ts_packet_fifo
// Packet-aware byte FIFO for the TS QoS path. Bytes of a packet are written
// tentatively and become visible to the reader only once the whole packet
// has arrived. Overflowing or misaligned packets are dropped whole.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous clear (drop_cnt survives)
//   wen/wdata/wsop      : write byte strobe, byte, start-of-packet marker
//   wfull, almost_full  : tentative occupancy flags
//   ren                 : read request
//   rdata/rvalid        : read byte and its valid, one cycle after ren
//   rsop/reop           : first/last byte of packet, qualified by rvalid
//   rempty              : no committed byte available
//   level, pkt_cnt      : committed bytes, packets available or partly read
//   drop_cnt/drop_pulse : dropped packet count (saturating) and pulse
//   sync_err            : pulse on packet alignment error
// ---------------------------------------------------------------------------
module ts_packet_fifo
    import ts_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int PKT_LEN    = TS_PKT_LEN,
    parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - PKT_LEN,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wsop,
    output logic                  wfull,
    output logic                  almost_full,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rsop,
    output logic                  reop,
    output logic                  rempty,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   pkt_cnt,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  drop_pulse,
    output logic                  sync_err
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int IW = $clog2(PKT_LEN + 1);
    localparam logic [PW-1:0] DEPTH_P  = PW'(2 ** ADDR_WIDTH);
    localparam logic [PW-1:0] AF_P     = PW'(AF_THRESH);
    localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]         widx_q, widx_d;
    logic [IW-1:0]         ridx_q, ridx_d;
    wr_state_e             state_q, state_d;
    logic [PW-1:0]         pkt_cnt_q, pkt_cnt_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  drop_pulse_q, drop_pulse_d;
    logic                  sync_err_q, sync_err_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rsop_q, rsop_d;
    logic                  reop_q, reop_d;

    logic [PW-1:0]         occ;
    logic                  cm_full;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic                  start_pkt, start_full, store, overflow, commit, pop_pkt;
    logic [PW-1:0]         start_base, store_base;
    logic [IW-1:0]         store_idx;

    assign occ         = wr_ptr_q - rd_ptr_q;
    // Occupancy seen after rewinding to the commit point.
    assign cm_full     = (cm_ptr_q - rd_ptr_q) == DEPTH_P;
    assign wfull       = (occ == DEPTH_P);
    assign almost_full = (occ >= AF_P);
    assign rempty      = (cm_ptr_q == rd_ptr_q);
    assign level       = cm_ptr_q - rd_ptr_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign drop_pulse  = drop_pulse_q;
    assign sync_err    = sync_err_q;
    assign rvalid      = rvalid_q;
    assign rsop        = rsop_q;
    assign reop        = reop_q;
    // RAM output register has no reset; hold rdata at zero when not valid.
    assign rdata       = rvalid_q ? ram_rdata : '0;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        cm_ptr_d     = cm_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        widx_d       = widx_q;
        ridx_d       = ridx_q;
        state_d      = state_q;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        drop_pulse_d = 1'b0;
        sync_err_d   = 1'b0;
        rvalid_d     = 1'b0;
        rsop_d       = 1'b0;
        reop_d       = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = wr_ptr_q[ADDR_WIDTH-1:0];
        rd_accept    = 1'b0;
        start_pkt    = 1'b0;
        start_full   = wfull;
        start_base   = wr_ptr_q;
        store        = 1'b0;
        store_base   = wr_ptr_q;
        store_idx    = widx_q;
        overflow     = 1'b0;
        commit       = 1'b0;
        pop_pkt      = 1'b0;

        if (flush) begin
            wr_ptr_d  = '0;
            cm_ptr_d  = '0;
            rd_ptr_d  = '0;
            widx_d    = '0;
            ridx_d    = '0;
            state_d   = WR_HUNT;
            pkt_cnt_d = '0;
        end else begin
            // ---- write framing ----
            if (wen) begin
                case (state_q)
                    WR_HUNT: begin
                        if (wsop) start_pkt  = 1'b1;
                        else      sync_err_d = 1'b1;
                    end
                    WR_FILL: begin
                        if (wsop) begin
                            start_pkt = 1'b1;
                            if (widx_q != '0) begin
                                // Early sop: abandon the partial packet and
                                // restart at the commit point.
                                sync_err_d = 1'b1;
                                start_base = cm_ptr_q;
                                start_full = cm_full;
                            end
                        end else if (widx_q == '0) begin
                            sync_err_d = 1'b1;
                            state_d    = WR_HUNT;
                        end else if (wfull) begin
                            overflow = 1'b1;
                        end else begin
                            store = 1'b1;
                        end
                    end
                    WR_DROP: begin
                        if (wsop) begin
                            start_pkt = 1'b1;
                        end else if (widx_q == LAST_IDX) begin
                            widx_d  = '0;
                            state_d = WR_FILL;
                        end else begin
                            widx_d = widx_q + IW'(1);
                        end
                    end
                    default: state_d = WR_HUNT;
                endcase
            end

            if (start_pkt) begin
                store_base = start_base;
                store_idx  = '0;
                if (start_full) overflow = 1'b1;
                else            store    = 1'b1;
            end

            if (overflow) begin
                wr_ptr_d     = cm_ptr_q;
                drop_pulse_d = 1'b1;
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
                if (store_idx == LAST_IDX) begin
                    widx_d  = '0;
                    state_d = WR_FILL;
                end else begin
                    widx_d  = store_idx + IW'(1);
                    state_d = WR_DROP;
                end
            end

            if (store) begin
                ram_we    = 1'b1;
                ram_waddr = store_base[ADDR_WIDTH-1:0];
                wr_ptr_d  = store_base + PW'(1);
                state_d   = WR_FILL;
                if (store_idx == LAST_IDX) begin
                    commit   = 1'b1;
                    cm_ptr_d = store_base + PW'(1);
                    widx_d   = '0;
                end else begin
                    widx_d = store_idx + IW'(1);
                end
            end

            // ---- read side: only committed bytes are ever addressed ----
            if (ren && !rempty) begin
                rd_accept = 1'b1;
                rvalid_d  = 1'b1;
                rsop_d    = (ridx_q == '0);
                reop_d    = (ridx_q == LAST_IDX);
                rd_ptr_d  = rd_ptr_q + PW'(1);
                if (ridx_q == LAST_IDX) begin
                    pop_pkt = 1'b1;
                    ridx_d  = '0;
                end else begin
                    ridx_d = ridx_q + IW'(1);
                end
            end

            pkt_cnt_d = pkt_cnt_q + PW'(commit) - PW'(pop_pkt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            cm_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            widx_q       <= '0;
            ridx_q       <= '0;
            state_q      <= WR_HUNT;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
            sync_err_q   <= 1'b0;
            rvalid_q     <= 1'b0;
            rsop_q       <= 1'b0;
            reop_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            widx_q       <= widx_d;
            ridx_q       <= ridx_d;
            state_q      <= state_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_pulse_d;
            sync_err_q   <= sync_err_d;
            rvalid_q     <= rvalid_d;
            rsop_q       <= rsop_d;
            reop_q       <= reop_d;
        end
    end

    ts_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (wdata),
        .re_i    (rd_accept),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

endmodule
